mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_rvalid
- if_addr  in  ADDR_W  fetch byte address
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  fetched instruction
- rready_cpu  in  1  data read request, level
- wvalid_cpu  in  1  data write request, level
- addr_cpu  in  ADDR_W  data byte address
- wdata_cpu  in  32  store data, pre-lane-aligned
- strb_cpu  in  4  store byte strobes
- rvalid_cpu  out  1  load data valid, 1-cycle pulse
- rdata_cpu  out  32  raw load word
- wready_cpu  out  1  store complete, 1-cycle pulse
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  write data
- mem_strb  out  4  write strobes; 4'b0000 on reads
- mem_resp_valid  in  1  memory response, 1 cycle, for reads and writes
- mem_rdata  in  32  read data, valid with mem_resp_valid

Function
REQ-004 SHALL implement FSM IDLE -> REQ -> RESP -> DONE -> IDLE with at most one outstanding memory transaction.
REQ-005 IDLE: if any request is pending, SHALL latch owner, address, we, wdata and strb, and go to REQ; otherwise it SHALL stay in IDLE.
REQ-006 Owner selection SHALL be round-robin via register last_owner: if both ports request, the port not equal to last_owner wins; a lone requester wins immediately.
REQ-007 Data port: wvalid_cpu SHALL take precedence over rready_cpu when both are high, making the transaction a write.
REQ-008 REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1; at that edge the FSM SHALL go to RESP and mem_req_valid SHALL drop.
REQ-009 RESP: on mem_resp_valid SHALL capture mem_rdata (on reads) into the owner's rdata register and go to DONE; it SHALL wait indefinitely otherwise.
REQ-010 DONE: SHALL assert exactly one of if_rvalid / rvalid_cpu / wready_cpu for 1 cycle, update last_owner, and return to IDLE; requests SHALL be ignored in DONE.
REQ-011 Best-case latency SHALL be 4 cycles from request sampled in IDLE to the valid pulse, with mem_req_ready=1 and the response one cycle after acceptance.
REQ-012 if_rdata/rdata_cpu SHALL hold their last captured value until the next read for that port.
REQ-013 Requests SHALL NOT be withdrawn before completion; withdrawal has undefined effect but SHALL NOT hang the FSM.
REQ-014 mem_resp_valid outside RESP SHALL be ignored.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, last_owner=data (instruction port first), and every output and data register to 0.
REQ-017 Reset mid-transaction SHALL abandon it with no valid pulse; memory is reset in the same domain.

Structure
REQ-018 arb_state_t (IDLE/REQ/RESP/DONE) and arb_owner_t (OWN_IF/OWN_DATA) SHALL live in shared package mem_arb_pkg.
REQ-019 Owner selection SHALL be sub-module arb_rr2: combinational grant from two requests and last_owner.

Verification
REQ-020 Lone fetch if_req=1, if_addr=0x100, mem_rdata=0x00500093, ready=1 -> mem_req_valid cycle 2, if_rvalid pulse cycle 4, if_rdata=0x00500093.
REQ-021 SB wvalid_cpu=1, addr=0x203, wdata=0xAB000000, strb=4'b1000 -> mem_we=1, mem_strb=4'b1000, wready_cpu one pulse, rvalid_cpu never asserted.
REQ-022 Both ports request continuously from reset -> grants alternate IF, DATA, IF, DATA; no port is starved.
REQ-023 mem_req_ready held low 5 cycles -> mem_req_valid and fields stay stable for all 5 cycles; completion follows the first ready.
REQ-024 rst_n low while in RESP, then released -> IDLE, all outputs 0, a stray mem_resp_valid is ignored, and the next fetch completes normally.
REQ-025 rready_cpu and wvalid_cpu both high -> write issued and only wready_cpu pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port identities
// and the byte-strobe width.
package mem_arb_pkg;

    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant: a lone requester wins, on contention the
// port that did not own the previous transaction wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       req_if,
    input  logic       req_data,
    input  arb_owner_t last_owner,
    output logic       grant_valid,
    output arb_owner_t grant
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = req_if | req_data;
        grant       = OWN_IF;
        if (req_if && req_data) begin
            grant = (last_owner == OWN_IF) ? OWN_DATA : OWN_IF;
        end else if (req_data) begin
            grant = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between the instruction-fetch port
// and the load/store port, alternating fairly under contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              rready_cpu,
    input  logic              wvalid_cpu,
    input  logic [ADDR_W-1:0] addr_cpu,
    input  logic [DATA_W-1:0] wdata_cpu,
    input  logic [STRB_W-1:0] strb_cpu,
    output logic              rvalid_cpu,
    output logic [DATA_W-1:0] rdata_cpu,
    output logic              wready_cpu,
    // memory port
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_strb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, state_next;
    arb_owner_t owner, last_owner, grant;
    logic       grant_valid;

    arb_rr2 u_arb (
        .req_if     (if_req),
        .req_data   (rready_cpu | wvalid_cpu),
        .last_owner (last_owner),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid)    state_next = REQ;
            REQ:     if (mem_req_ready)  state_next = RESP;
            RESP:    if (mem_resp_valid) state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // NOTE: data registers are reset too, so no stale address or read data is visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= OWN_IF;
            last_owner    <= OWN_DATA;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_strb      <= '0;
            if_rvalid     <= 1'b0;
            if_rdata      <= '0;
            rvalid_cpu    <= 1'b0;
            rdata_cpu     <= '0;
            wready_cpu    <= 1'b0;
        end else begin
            if_rvalid  <= 1'b0;
            rvalid_cpu <= 1'b0;
            wready_cpu <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant;
                        mem_req_valid <= 1'b1;
                        if (grant == OWN_IF) begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_strb  <= '0;
                        end else begin
                            // a simultaneous load and store resolves to the store
                            mem_addr  <= addr_cpu;
                            mem_we    <= wvalid_cpu;
                            mem_wdata <= wvalid_cpu ? wdata_cpu : '0;
                            mem_strb  <= wvalid_cpu ? strb_cpu : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        if (owner == OWN_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else if (mem_we) begin
                            wready_cpu <= 1'b1;
                        end else begin
                            rvalid_cpu <= 1'b1;
                            rdata_cpu  <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a word-level memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        rready_cpu;
    logic        wvalid_cpu;
    logic [31:0] addr_cpu;
    logic [31:0] wdata_cpu;
    logic [3:0]  strb_cpu;
    logic        rvalid_cpu;
    logic [31:0] rdata_cpu;
    logic        wready_cpu;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic [2:0]  pulses;
    assign pulses = {if_rvalid, rvalid_cpu, wready_cpu};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .rready_cpu    (rready_cpu),
        .wvalid_cpu    (wvalid_cpu),
        .addr_cpu      (addr_cpu),
        .wdata_cpu     (wdata_cpu),
        .strb_cpu      (strb_cpu),
        .rvalid_cpu    (rvalid_cpu),
        .rdata_cpu     (rdata_cpu),
        .wready_cpu    (wready_cpu),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_strb      (mem_strb),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two memory images: bus_mem follows what the DUT issues, ref_mem follows what the CPU meant.
    logic [31:0] bus_mem [int];
    logic [31:0] ref_mem [int];

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]} & 32'hFFFF_FFFC | {30'd0, a[3:2]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return bus_mem.exists(widx(a)) ? bus_mem[widx(a)] : dflt({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : dflt({a[31:2], 2'b00});
    endfunction

    // Memory responder knobs
    int ready_pct  = 100;
    int resp_dmin  = 0;
    int resp_dmax  = 0;
    int stall_left = 0;
    bit stray      = 1'b0;

    initial begin : responder
        bit          pend;
        int          cnt;
        logic [31:0] rd;
        pend = 1'b0;
        cnt  = 0;
        rd   = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            if (rst_n && mem_req_valid && mem_req_ready) begin
                if (mem_we) begin
                    bus_mem[widx(mem_addr)] = merge(bus_word(mem_addr), mem_wdata, mem_strb);
                    rd = '0;
                end else begin
                    check("read_strb_zero", mem_strb, 4'b0000);
                    rd = bus_word(mem_addr);
                end
                pend = 1'b1;
                cnt  = $urandom_range(resp_dmax, resp_dmin);
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = rd;
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (stray) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hDEAD_BEEF;
                stray          = 1'b0;
            end
            if (stall_left > 0) begin
                mem_req_ready = 1'b0;
                if (mem_req_valid) stall_left--;
            end else begin
                mem_req_ready = ($urandom_range(99, 0) < ready_pct);
            end
        end
    end

    // A port left waiting when the other port completes must own the next completion.
    bit fair_en = 1'b0;
    initial begin : fair_mon
        int owed;
        int port;
        owed = -1;
        forever begin
            @(negedge clk);
            if (!fair_en) begin
                owed = -1;
            end else if (pulses != 3'b000) begin
                port = if_rvalid ? 0 : 1;
                if (owed >= 0) check("rr_fair", port, owed);
                owed = -1;
                if (port == 0 && (rready_cpu || wvalid_cpu)) owed = 1;
                else if (port == 1 && if_req) owed = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        bit          use_if;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          preload;
        logic [31:0] init_word;
        bit          exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_pulse;   // {if_rvalid, rvalid_cpu, wready_cpu}
    } vec_t;

    function automatic vec_t mk(input string name, input bit use_if, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input bit preload,
                                input logic [31:0] init_word, input bit exp_we,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rdata, input logic [2:0] exp_pulse);
        vec_t v;
        v.name = name; v.use_if = use_if; v.rd = rd; v.wr = wr;
        v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.preload = preload; v.init_word = init_word;
        v.exp_we = exp_we; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
        v.exp_rdata = exp_rdata; v.exp_pulse = exp_pulse;
        return v;
    endfunction

    logic [31:0] last_if = '0;
    logic [31:0] last_d  = '0;

    task automatic check_idle_zero(input string tag);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_we"},        mem_we,        0);
        check({tag, "_mem_addr"},      mem_addr,      0);
        check({tag, "_mem_wdata"},     mem_wdata,     0);
        check({tag, "_mem_strb"},      mem_strb,      0);
        check({tag, "_pulses"},        pulses,        0);
        check({tag, "_if_rdata"},      if_rdata,      0);
        check({tag, "_rdata_cpu"},     rdata_cpu,     0);
    endtask

    // Best-case single transaction; called at posedge+1 with the DUT idle.
    task automatic run_vec(input vec_t v);
        if (v.preload) bus_mem[widx(v.addr)] = v.init_word;
        if (v.use_if) begin
            if_addr = v.addr;
            if_req  = 1'b1;
        end else begin
            addr_cpu   = v.addr;
            wdata_cpu  = v.wdata;
            strb_cpu   = v.strb;
            rready_cpu = v.rd;
            wvalid_cpu = v.wr;
        end
        @(negedge clk);
        check({v.name, "_c1_valid"}, mem_req_valid, 0);
        @(negedge clk);
        check({v.name, "_c2_valid"}, mem_req_valid, 1);
        check({v.name, "_c2_we"},    mem_we,        v.exp_we);
        check({v.name, "_c2_addr"},  mem_addr,      v.addr);
        check({v.name, "_c2_strb"},  mem_strb,      v.exp_strb);
        if (v.exp_we) check({v.name, "_c2_wdata"}, mem_wdata, v.exp_wdata);
        check({v.name, "_c2_pulses"}, pulses, 0);
        @(negedge clk);
        check({v.name, "_c3_valid"},  mem_req_valid, 0);
        check({v.name, "_c3_pulses"}, pulses, 0);
        if (v.exp_pulse == 3'b100) last_if = v.exp_rdata;
        if (v.exp_pulse == 3'b010) last_d  = v.exp_rdata;
        @(negedge clk);
        check({v.name, "_c4_pulses"},    pulses,    v.exp_pulse);
        check({v.name, "_c4_if_rdata"},  if_rdata,  last_if);
        check({v.name, "_c4_rdata_cpu"}, rdata_cpu, last_d);
        @(posedge clk);
        #1;
        if_req     = 1'b0;
        rready_cpu = 1'b0;
        wvalid_cpu = 1'b0;
        @(negedge clk);
        check({v.name, "_c5_pulses"}, pulses, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic if_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            logic [31:0] a;
            bit          got;
            gap = $urandom_range(3, 0);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            a       = {24'd0, 6'($urandom_range(63, 0)), 2'b00};
            if_addr = a;
            if_req  = 1'b1;
            got     = 1'b0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (if_rvalid) begin
                    got = 1'b1;
                    check("rand_if_rdata", if_rdata, ref_word(a));
                end
            end
            check("rand_if_done", got, 1);
            @(posedge clk);
            #1;
            if_req = 1'b0;
        end
    endtask

    task automatic data_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int          gap;
            int          op;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  st;
            bit          is_wr;
            bit          got;
            gap = $urandom_range(3, 0);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            op    = $urandom_range(3, 0);
            a     = 32'h1000 + {26'd0, 4'($urandom_range(15, 0)), 2'b00};
            wd    = $urandom;
            st    = 4'($urandom_range(15, 0));
            is_wr = (op >= 2);
            addr_cpu   = a;
            wdata_cpu  = wd;
            strb_cpu   = st;
            rready_cpu = (op != 2);
            wvalid_cpu = is_wr;
            got        = 1'b0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (rvalid_cpu || wready_cpu) begin
                    got = 1'b1;
                    check("rand_data_kind", {rvalid_cpu, wready_cpu}, is_wr ? 2'b01 : 2'b10);
                    if (is_wr) ref_mem[widx(a)] = merge(ref_word(a), wd, st);
                    else check("rand_lw_rdata", rdata_cpu, ref_word(a));
                end
            end
            check("rand_data_done", got, 1);
            @(posedge clk);
            #1;
            rready_cpu = 1'b0;
            wvalid_cpu = 1'b0;
        end
    endtask

    initial begin : main
        vec_t vecs[6];
        int   seen;
        int   port;

        vecs[0] = mk("fetch_lone", 1, 0, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0050_0093,
                     0, 4'b0000, 32'h0, 32'h0050_0093, 3'b100);
        vecs[1] = mk("sb",         0, 0, 1, 32'h203, 32'hAB00_0000, 4'b1000, 1, 32'h1122_3344,
                     1, 4'b1000, 32'hAB00_0000, 32'h0, 3'b001);
        vecs[2] = mk("lw_after_sb", 0, 1, 0, 32'h200, 32'h0, 4'h0, 0, 32'h0,
                     0, 4'b0000, 32'h0, 32'hAB22_3344, 3'b010);
        vecs[3] = mk("rd_and_wr",  0, 1, 1, 32'h300, 32'hCAFE_F00D, 4'b1111, 0, 32'h0,
                     1, 4'b1111, 32'hCAFE_F00D, 32'h0, 3'b001);
        vecs[4] = mk("lw_full",    0, 1, 0, 32'h300, 32'h0, 4'h0, 0, 32'h0,
                     0, 4'b0000, 32'h0, 32'hCAFE_F00D, 3'b010);
        vecs[5] = mk("fetch_next", 1, 0, 0, 32'h104, 32'h0, 4'h0, 1, 32'h1234_5678,
                     0, 4'b0000, 32'h0, 32'h1234_5678, 3'b100);

        // Both ports already requesting while reset is applied
        rst_n      = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h40;
        rready_cpu = 1'b1;
        wvalid_cpu = 1'b0;
        addr_cpu   = 32'h1040;
        wdata_cpu  = '0;
        strb_cpu   = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        seen = 0;
        for (int t = 0; t < 80 && seen < 4; t++) begin
            @(negedge clk);
            if (pulses != 3'b000) begin
                port = if_rvalid ? 0 : 1;
                check($sformatf("alt_grant_%0d", seen), port, seen % 2);
                if (if_rvalid) check("alt_if_rdata", if_rdata, ref_word(32'h40));
                else begin
                    check("alt_data_kind", pulses, 3'b010);
                    check("alt_rdata_cpu", rdata_cpu, ref_word(32'h1040));
                end
                seen++;
            end
        end
        check("alt_count", seen, 4);
        @(posedge clk);
        #1;
        if_req     = 1'b0;
        rready_cpu = 1'b0;
        last_if    = ref_word(32'h40);
        last_d     = ref_word(32'h1040);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Five cycles of back-pressure on the memory request
        bus_mem[widx(32'h108)] = 32'hA5A5_0001;
        stall_left = 5;
        if_addr    = 32'h108;
        if_req     = 1'b1;
        @(negedge clk);
        check("stall_c1_valid", mem_req_valid, 0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("stall_c%0d_valid", c), mem_req_valid, 1);
            check($sformatf("stall_c%0d_addr", c), mem_addr, 32'h108);
            check($sformatf("stall_c%0d_we", c), mem_we, 0);
            check($sformatf("stall_c%0d_strb", c), mem_strb, 0);
            check($sformatf("stall_c%0d_pulses", c), pulses, 0);
        end
        @(negedge clk);
        check("stall_c7_valid", mem_req_valid, 1);
        check("stall_c7_addr", mem_addr, 32'h108);
        @(negedge clk);
        check("stall_c8_valid", mem_req_valid, 0);
        check("stall_c8_pulses", pulses, 0);
        @(negedge clk);
        check("stall_c9_pulses", pulses, 3'b100);
        check("stall_c9_if_rdata", if_rdata, 32'hA5A5_0001);
        check("stall_c9_rdata_cpu", rdata_cpu, last_d);
        @(posedge clk);
        #1;
        if_req = 1'b0;

        // Reset while waiting for a response, then a stray response in IDLE
        bus_mem[widx(32'h10C)] = 32'h0BAD_F00D;
        resp_dmin = 3;
        resp_dmax = 3;
        if_addr   = 32'h10C;
        if_req    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_c3_valid", mem_req_valid, 0);
        check("rst_c3_pulses", pulses, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check_idle_zero("mid_rst");
        resp_dmin = 0;
        resp_dmax = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stray_pulses", pulses, 0);
            check("stray_valid", mem_req_valid, 0);
            check("stray_if_rdata", if_rdata, 0);
        end
        last_if = '0;
        last_d  = '0;
        @(posedge clk);
        #1;
        run_vec(vecs[0]);

        // Randomized contention with back-pressure and variable response delay
        ready_pct = 70;
        resp_dmin = 0;
        resp_dmax = 3;
        fair_en   = 1'b1;
        fork
            if_driver(40);
            data_driver(40);
        join
        fair_en   = 1'b0;
        ready_pct = 100;
        resp_dmax = 0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
